// File: rtl/key_digit_buffer.sv
// key_digit_buffer: debounced keypad digit entry buffer.
// Synchronizes the keypad encoder outputs, debounces the strobe, and keeps a
// shift buffer of up to DIGITS 4-bit digits with clear and backspace.
// Optional build macro: KEY_DIGIT_BUFFER_ROLL_EN -- when defined, an accept
// into a full buffer drops the oldest digit instead of pulsing overflow.
module key_digit_buffer #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic                  hz100,
    input  logic                  reset,
    input  logic [3:0]            code,
    input  logic                  strobe,
    input  logic                  clear,
    input  logic                  back,
    output logic [4*DIGITS-1:0]   digits,
    output logic [3:0]            count,
    output logic                  full,
    output logic                  key_pulse,
    output logic [3:0]            key_code,
    output logic                  overflow
);

    localparam int unsigned DW      = 4 * DIGITS;
    localparam logic [3:0]  DEB_CNT = 4'(DEBOUNCE);
    localparam logic [3:0]  MAX_CNT = 4'(DIGITS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  stab_cnt;

    logic [3:0]  code_s1, code_s2;
    logic        strobe_s1, strobe_s2;
    logic        clear_s1, clear_s2;
    logic        back_s1, back_s2;
    logic        back_prev;
    logic [1:0]  sync_primed;

    logic        accept_c;
    logic        back_rise_c;
    logic [DW-1:0] digits_shl_c;
    logic [DW-1:0] digits_shr_c;

    // Two-flop synchronizers; sync_primed marks when stage two holds a real
    // pin sample again after reset, so the back edge detector ignores the
    // zeros reset leaves in the pipeline.
    always_ff @(posedge hz100) begin
        if (!reset) begin
            code_s1     <= 4'd0;
            code_s2     <= 4'd0;
            strobe_s1   <= 1'b0;
            strobe_s2   <= 1'b0;
            clear_s1    <= 1'b0;
            clear_s2    <= 1'b0;
            back_s1     <= 1'b0;
            back_s2     <= 1'b0;
            sync_primed <= 2'b00;
        end else begin
            code_s1     <= code;
            code_s2     <= code_s1;
            strobe_s1   <= strobe;
            strobe_s2   <= strobe_s1;
            clear_s1    <= clear;
            clear_s2    <= clear_s1;
            back_s1     <= back;
            back_s2     <= back_s1;
            sync_primed <= {sync_primed[0], 1'b1};
        end
    end

    // Back edge history; loaded to 1 so a button held through reset is not a press.
    always_ff @(posedge hz100) begin
        if (!reset) begin
            back_prev <= 1'b1;
        end else if (sync_primed[1]) begin
            back_prev <= back_s2;
        end
    end

    // Event decode and shifted buffer candidates.
    always_comb begin
        accept_c     = (state == ARMING) && strobe_s2 && (stab_cnt == DEB_CNT);
        back_rise_c  = sync_primed[1] && back_s2 && !back_prev;
        digits_shl_c = (digits << 4) | DW'(code_s2);
        digits_shr_c = digits >> 4;
    end

    // Strobe debounce FSM with stability counter.
    always_ff @(posedge hz100) begin
        if (!reset) begin
            state    <= IDLE;
            stab_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe_s2) begin
                        state    <= ARMING;
                        stab_cnt <= 4'd1;
                    end
                end
                ARMING: begin
                    if (!strobe_s2) begin
                        state <= IDLE;
                    end else if (stab_cnt == DEB_CNT) begin
                        state <= HELD;
                    end else begin
                        stab_cnt <= stab_cnt + 4'd1;
                    end
                end
                HELD: begin
                    if (!strobe_s2) begin
                        state    <= RELEASING;
                        stab_cnt <= 4'd1;
                    end
                end
                RELEASING: begin
                    if (strobe_s2) begin
                        state <= HELD;
                    end else if (stab_cnt == DEB_CNT) begin
                        state <= IDLE;
                    end else begin
                        stab_cnt <= stab_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    stab_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Digit buffer: clear beats accept beats back; losers are dropped, not queued.
    always_ff @(posedge hz100) begin
        if (!reset) begin
            digits    <= '0;
            count     <= 4'd0;
            full      <= 1'b0;
            key_pulse <= 1'b0;
            key_code  <= 4'd0;
            overflow  <= 1'b0;
        end else begin
            key_pulse <= 1'b0;
            overflow  <= 1'b0;
            if (clear_s2) begin
                digits <= '0;
                count  <= 4'd0;
                full   <= 1'b0;
            end else if (accept_c) begin
                key_code <= code_s2;
                if (count < MAX_CNT) begin
                    digits    <= digits_shl_c;
                    count     <= count + 4'd1;
                    full      <= ((count + 4'd1) == MAX_CNT);
                    key_pulse <= 1'b1;
                end else begin
`ifdef KEY_DIGIT_BUFFER_ROLL_EN
                    digits    <= digits_shl_c;
                    key_pulse <= 1'b1;
`else
                    overflow  <= 1'b1;
`endif
                end
            end else if (back_rise_c && (count != 4'd0)) begin
                digits <= digits_shr_c;
                count  <= count - 4'd1;
                full   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_digit_buffer.sv
// Self-checking bench for key_digit_buffer (DIGITS=8, DEBOUNCE=2).
// Reference model: digit queue plus run-length debounce of the delayed pins.
module tb_key_digit_buffer;

    localparam int unsigned DIGITS   = 8;
    localparam int unsigned DEBOUNCE = 2;

    logic        hz100 = 1'b0;
    logic        reset;
    logic [3:0]  code;
    logic        strobe;
    logic        clear;
    logic        back;
    logic [31:0] digits;
    logic [3:0]  count;
    logic        full;
    logic        key_pulse;
    logic [3:0]  key_code;
    logic        overflow;

    key_digit_buffer #(.DIGITS(DIGITS), .DEBOUNCE(DEBOUNCE)) dut (
        .hz100     (hz100),
        .reset     (reset),
        .code      (code),
        .strobe    (strobe),
        .clear     (clear),
        .back      (back),
        .digits    (digits),
        .count     (count),
        .full      (full),
        .key_pulse (key_pulse),
        .key_code  (key_code),
        .overflow  (overflow)
    );

    always #5 hz100 = ~hz100;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int unsigned mq[$];          // digits, oldest at front
    logic [3:0]  m_key_code;
    bit          m_pulse, m_ovf;
    bit          m_pressed;
    int          hi_run, lo_run;
    bit          m_bprev;
    int          since_rst;
    bit          ps[2], pcl[2], pb[2];
    logic [3:0]  pc[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_key_code = 4'd0;
        m_pulse = 0; m_ovf = 0; m_pressed = 0;
        hi_run = 0; lo_run = 0;
        m_bprev = 1; since_rst = 0;
        for (int i = 0; i < 2; i++) begin
            ps[i] = 0; pcl[i] = 0; pb[i] = 0; pc[i] = 4'd0;
        end
    endtask

    // One clock edge of the reference model, using the pin values just sampled.
    task automatic model_edge();
        bit ds, dcl, db, acc, rise;
        logic [3:0] dc;
        if (!reset) begin
            model_reset();
            return;
        end
        since_rst++;
        ds = ps[0]; dc = pc[0]; dcl = pcl[0]; db = pb[0];
        ps[0] = ps[1];   ps[1] = strobe;
        pc[0] = pc[1];   pc[1] = code;
        pcl[0] = pcl[1]; pcl[1] = clear;
        pb[0] = pb[1];   pb[1] = back;

        if (ds) begin hi_run++; lo_run = 0; end
        else    begin lo_run++; hi_run = 0; end
        acc = 0;
        if (!m_pressed && hi_run == int'(DEBOUNCE) + 1) begin
            acc = 1; m_pressed = 1;
        end else if (m_pressed && lo_run == int'(DEBOUNCE) + 1) begin
            m_pressed = 0;
        end

        rise = 0;
        if (since_rst >= 3) begin
            rise = db && !m_bprev;
            m_bprev = db;
        end

        m_pulse = 0; m_ovf = 0;
        if (dcl) begin
            mq.delete();
        end else if (acc) begin
            m_key_code = dc;
            if (mq.size() < DIGITS) begin
                mq.push_back(dc); m_pulse = 1;
            end else begin
`ifdef KEY_DIGIT_BUFFER_ROLL_EN
                mq.push_back(dc); void'(mq.pop_front()); m_pulse = 1;
`else
                m_ovf = 1;
`endif
            end
        end else if (rise && mq.size() > 0) begin
            void'(mq.pop_back());
        end
    endtask

    function automatic logic [31:0] model_digits();
        logic [31:0] v = 32'd0;
        foreach (mq[i]) v = (v << 4) | 32'(mq[i]);
        return v;
    endfunction

    task automatic check_all();
        chk("digits",    digits,          model_digits());
        chk("count",     32'(count),      32'(mq.size()));
        chk("full",      32'(full),       32'(mq.size() == DIGITS));
        chk("key_pulse", 32'(key_pulse),  32'(m_pulse));
        chk("key_code",  32'(key_code),   32'(m_key_code));
        chk("overflow",  32'(overflow),   32'(m_ovf));
    endtask

    task automatic tick();
        @(posedge hz100);
        model_edge();
        #1;
        check_all();
    endtask

    int npulse, novf, pulse_at;

    task automatic press_key(input logic [3:0] k);
        code = k; strobe = 1'b1;
        repeat (6) begin
            tick();
            npulse += int'(key_pulse); novf += int'(overflow);
        end
        strobe = 1'b0;
        repeat (6) begin
            tick();
            npulse += int'(key_pulse); novf += int'(overflow);
        end
    endtask

    initial begin
        model_reset();
        reset = 1'b0; code = 4'd0; strobe = 1'b0; clear = 1'b0; back = 1'b0;
        repeat (3) tick();
        chk("reset_digits", digits, 32'd0);
        chk("reset_code",   32'(key_code), 32'd0);
        reset = 1'b1;
        repeat (3) tick();

        // Single press of 5 held for 10 cycles
        code = 4'd5; strobe = 1'b1; npulse = 0; pulse_at = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (key_pulse === 1'b1) begin
                npulse++;
                if (pulse_at < 0) pulse_at = i;
            end
        end
        strobe = 1'b0;
        repeat (6) tick();
        chk("press_latency", 32'(pulse_at), 32'd4);
        chk("press_pulses",  32'(npulse), 32'd1);
        chk("press_digits",  digits, 32'h0000_0005);
        chk("press_count",   32'(count), 32'd1);
        chk("press_code",    32'(key_code), 32'd5);

        // One-cycle strobe glitch
        code = 4'd3; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        repeat (8) tick();
        chk("glitch_digits", digits, 32'h0000_0005);
        chk("glitch_code",   32'(key_code), 32'd5);

        // Clear, then enter 1..9
        clear = 1'b1; repeat (3) tick();
        clear = 1'b0; repeat (3) tick();
        npulse = 0; novf = 0;
        for (int k = 1; k <= 9; k++) press_key(4'(k));
`ifdef KEY_DIGIT_BUFFER_ROLL_EN
        chk("fill_digits", digits, 32'h2345_6789);
        chk("fill_pulses", 32'(npulse), 32'd9);
        chk("fill_ovf",    32'(novf), 32'd0);
`else
        chk("fill_digits", digits, 32'h1234_5678);
        chk("fill_pulses", 32'(npulse), 32'd8);
        chk("fill_ovf",    32'(novf), 32'd1);
`endif
        chk("fill_full",  32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_code",  32'(key_code), 32'd9);

        // Hold back for 20 cycles: exactly one delete
        back = 1'b1; repeat (20) tick();
        back = 1'b0; repeat (4) tick();
`ifdef KEY_DIGIT_BUFFER_ROLL_EN
        chk("back_digits", digits, 32'h0234_5678);
`else
        chk("back_digits", digits, 32'h0123_4567);
`endif
        chk("back_count", 32'(count), 32'd7);
        chk("back_full",  32'(full), 32'd0);

        // Clear synced on the same edge as an accept
        code = 4'd7; strobe = 1'b1; npulse = 0;
        tick(); tick();
        clear = 1'b1; tick();
        clear = 1'b0;
        repeat (6) begin tick(); npulse += int'(key_pulse); end
        strobe = 1'b0;
        repeat (6) begin tick(); npulse += int'(key_pulse); end
        chk("clracc_digits", digits, 32'd0);
        chk("clracc_count",  32'(count), 32'd0);
        chk("clracc_pulses", 32'(npulse), 32'd0);

        // Reset for one cycle mid-ARMING with strobe held
        code = 4'd4; strobe = 1'b1; npulse = 0;
        repeat (3) begin tick(); npulse += int'(key_pulse); end
        chk("arm_nopulse", 32'(npulse), 32'd0);
        reset = 1'b0; tick();
        reset = 1'b1;
        repeat (10) begin tick(); npulse += int'(key_pulse); end
        strobe = 1'b0;
        repeat (6) begin tick(); npulse += int'(key_pulse); end
        chk("arm_pulses", 32'(npulse), 32'd1);
        chk("arm_digits", digits, 32'h0000_0004);

        // Back held through reset release, then randomized traffic
        back = 1'b1; reset = 1'b0; tick();
        reset = 1'b1; repeat (8) tick();
        back = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5, 0) == 0) begin
                strobe = ~strobe;
                if (strobe) code = 4'($urandom_range(15, 0));
            end
            if ($urandom_range(9, 0) == 0) back = ~back;
            clear = ($urandom_range(59, 0) == 0);
            reset = ($urandom_range(399, 0) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/key_digit_buffer.md
KEY_DIGIT_BUFFER -- requirements
Module: key_digit_buffer

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of 4-bit digit slots held (legal 1..8).
REQ-002 SHALL have parameter DEBOUNCE, default 2, consecutive synchronized samples required to accept a press or a release (legal 1..15).
REQ-003 hz100  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset (0 = reset, sampled on hz100 rising edge).
REQ-005 code  in  4  encoded key index from the upstream 16-to-4 key encoder; asynchronous.
REQ-006 strobe  in  1  high while any key is pressed; asynchronous.
REQ-007 clear  in  1  level; empties the buffer.
REQ-008 back  in  1  level; rising edge deletes the newest digit.
REQ-009 digits  out  4*DIGITS  digit buffer; newest digit in bits [3:0].
REQ-010 count  out  4  number of valid digits, 0..DIGITS.
REQ-011 full  out  1  high when count == DIGITS.
REQ-012 key_pulse  out  1  one-cycle pulse when a key is written into the buffer.
REQ-013 key_code  out  4  code of the most recently accepted key; holds between accepts.
REQ-014 overflow  out  1  one-cycle pulse when an accepted key is discarded because the buffer is full.

Function
REQ-015 code, strobe, clear and back SHALL each pass through a 2-flop synchronizer before use.
REQ-016 The debounce FSM SHALL use states IDLE, ARMING, HELD and RELEASING, with a 4-bit stability counter.
REQ-017 IDLE: synced strobe = 1 -> ARMING with counter = 1; else stay in IDLE.
REQ-018 ARMING: synced strobe = 0 -> IDLE. When counter reaches DEBOUNCE with strobe still high -> accept the key and go to HELD. Otherwise increment the counter.
REQ-019 HELD: synced strobe = 0 -> RELEASING with counter = 1; no further accepts while in HELD.
REQ-020 RELEASING: synced strobe = 1 -> HELD. When counter reaches DEBOUNCE with strobe still low -> IDLE. Otherwise increment the counter.
REQ-021 Accept SHALL capture the synced code. key_pulse, key_code, digits and count SHALL update on the edge DEBOUNCE+2 cycles after strobe is first sampled high at the pin.
REQ-022 Accept with count < DIGITS SHALL:
  - shift digits left by 4 and insert the code at [3:0];
  - increment count;
  - pulse key_pulse.
REQ-023 Accept with count == DIGITS and no roll (see REQ-033) SHALL leave digits and count unchanged, pulse overflow, keep key_pulse low, and update key_code.
REQ-024 A back rising edge (synced) SHALL shift digits right by 4, fill zero at the top, and decrement count; it SHALL do nothing when count == 0.
REQ-025 clear high (synced) SHALL zero digits and count every cycle it is high; key_code is unaffected.
REQ-026 Same-cycle priority SHALL be clear > accept > back. A lower-priority event in that cycle is discarded, not deferred; the FSM still advances normally.
REQ-027 Holding back high SHALL produce exactly one delete; holding a key SHALL produce exactly one accept.

Reset
REQ-028 While reset = 0 at a clock edge SHALL set:
  - digits = 0, count = 0, full = 0;
  - key_pulse = 0, key_code = 0, overflow = 0;
  - FSM = IDLE, counter = 0, synchronizers = 0.
REQ-029 Reset SHALL load the back edge-detect history to 1, so a back button held through reset release causes no delete.
REQ-030 Reset asserted mid-ARMING or mid-RELEASING SHALL abort the debounce with no pulse.
REQ-031 After reset release, a still-held key SHALL be treated as a new press and re-debounced.

Configuration
REQ-032 Macro KEY_DIGIT_BUFFER_ROLL_EN SHALL select the full-buffer policy.
REQ-033 With the macro defined, an accept at count == DIGITS SHALL:
  - shift the code in and drop the oldest digit;
  - keep count = DIGITS;
  - pulse key_pulse;
  - keep overflow permanently 0.
REQ-034 With the macro undefined, REQ-023 SHALL apply.

Verification (DIGITS = 8, DEBOUNCE = 2)
REQ-035 Reset, then code = 5 with strobe held 10 cycles -> one key_pulse, 4 edges after first sample; digits = 0x00000005, count = 1, key_code = 5.
REQ-036 1-cycle strobe glitch with code = 3 -> no key_pulse; digits and count unchanged.
REQ-037 Enter keys 1..8, then 9:
  - macro undefined -> digits = 0x12345678, full = 1, one overflow pulse;
  - macro defined -> digits = 0x23456789, count = 8.
REQ-038 From digits = 0x12345678, count = 8, hold back 20 cycles -> digits = 0x01234567, count = 7, with exactly one shift.
REQ-039 clear high on the same edge as an accept -> digits = 0, count = 0, no key_pulse.
REQ-040 reset low for 1 cycle while in ARMING, strobe held throughout -> no pulse before reset; after release, exactly one accept after re-debounce.
